ftdi_tx_arb: RTL and testbench

FTDI_TX_ARB -- requirements
Module: ftdi_tx_arb

---
 rtl/ftdi_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/ftdi_tx_arb.sv | 138 +++++++++++++
 tb/tb_ftdi_tx_arb.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ftdi_pkg.sv
// Shared types and constants for the FTDI transmit arbiter slice.
// No logic; state encoding, header nibble and byte width only.
package ftdi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic [3:0] HDR_NIBBLE = 4'hA;
    localparam int         BYTE_W     = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick of the next owner among active requests, rotating past the last owner.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is registered.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_owner,
    output logic [N_REQ-1:0] gnt
);

    logic [IDX_W:0] cand;

    always_comb begin
        gnt  = '0;
        cand = '0;
        // Walk from farthest to nearest so the nearest active request wins.
        for (int k = N_REQ; k >= 1; k--) begin
            cand = {1'b0, last_owner} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N_REQ)) begin
                cand = cand - (IDX_W+1)'(N_REQ);
            end
            if (req[cand[IDX_W-1:0]]) begin
                gnt                   = '0;
                gnt[cand[IDX_W-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ftdi_tx_arb.sv
// Packet arbiter from N byte streams onto one FTDI FIFO port; FTDI_TX_ARB_HDR_EN adds a per-packet header byte.
// Latency: 1 cycle requester byte to d; 1 byte/clk while txe=0.
// Backpressure: txe high freezes the output register, state and arbitration; req_rdy drops while a byte is held.
module ftdi_tx_arb
    import ftdi_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int MAX_LEN = 256
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic [N_REQ-1:0]   req_vld,
    input  logic [8*N_REQ-1:0] req_d,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_rdy,
    input  logic               txe,
    output logic               wr,
    output logic [7:0]         d,
    output logic [N_REQ-1:0]   grant,
    output logic               busy,
    output logic               len_err
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_LEN + 1);

    state_t              state;
    logic                out_vld;
    logic [BYTE_W-1:0]   out_byte;
    logic [IDX_W-1:0]    owner;
    logic [IDX_W-1:0]    last_owner;
    logic [IDX_W-1:0]    nxt_idx;
    logic [N_REQ-1:0]    nxt_gnt;
    logic [CNT_W-1:0]    len_cnt;
    logic [BYTE_W-1:0]   in_byte;
    logic                in_last;
    logic                in_xfer;
    logic                len_hit;
    logic                pkt_end;
    logic                out_free;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req        (req_vld),
        .last_owner (last_owner),
        .gnt        (nxt_gnt)
    );

    // The register can take a new byte when empty or when its byte leaves this cycle.
    assign out_free = ~out_vld | ~txe;
    assign wr       = ~(out_vld & ~txe);
    assign d        = out_byte;
    assign busy     = (state != ST_IDLE) | out_vld;
    assign req_rdy  = grant & {N_REQ{(state == ST_DATA) & out_free}};
    assign in_xfer  = |(req_vld & req_rdy);
    assign len_hit  = (len_cnt == CNT_W'(MAX_LEN - 1));
    assign pkt_end  = in_xfer & (in_last | len_hit);

    always_comb begin
        in_byte = '0;
        in_last = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                in_byte = req_d[8*i +: 8];
                in_last = req_last[i];
            end
        end
    end

    always_comb begin
        nxt_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (nxt_gnt[i]) begin
                nxt_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= ST_IDLE;
            out_vld    <= 1'b0;
            out_byte   <= '0;
            grant      <= '0;
            owner      <= '0;
            last_owner <= IDX_W'(N_REQ - 1);
            len_cnt    <= '0;
            len_err    <= 1'b0;
        end else begin
            len_err <= 1'b0;
            if (out_vld & ~txe) begin
                out_vld <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if ((|req_vld) & ~txe) begin
                        grant <= nxt_gnt;
                        owner <= nxt_idx;
`ifdef FTDI_TX_ARB_HDR_EN
                        state <= ST_HDR;
`else
                        state <= ST_DATA;
`endif
                    end
                end
`ifdef FTDI_TX_ARB_HDR_EN
                ST_HDR: begin
                    if (out_free) begin
                        out_vld  <= 1'b1;
                        out_byte <= {HDR_NIBBLE, 4'(owner)};
                        state    <= ST_DATA;
                    end
                end
`endif
                ST_DATA: begin
                    if (in_xfer) begin
                        out_vld  <= 1'b1;
                        out_byte <= in_byte;
                        if (pkt_end) begin
                            // A length-forced end leaves the rest for this requester's next grant.
                            state      <= ST_IDLE;
                            grant      <= '0;
                            last_owner <= owner;
                            len_cnt    <= '0;
                            len_err    <= ~in_last;
                        end else begin
                            len_cnt <= len_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ftdi_tx_arb.sv
// Directed bench for ftdi_tx_arb with MAX_LEN=4; expectations adapt to the header build option.
module tb_ftdi_tx_arb;

    localparam int N = 4;
`ifdef FTDI_TX_ARB_HDR_EN
    localparam int H = 1;
`else
    localparam int H = 0;
`endif

    logic           clk = 1'b0;
    logic           n_rst;
    logic [N-1:0]   req_vld;
    logic [8*N-1:0] req_d;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_rdy;
    logic           txe;
    logic           wr;
    logic [7:0]     d;
    logic [N-1:0]   grant;
    logic           busy;
    logic           len_err;

    ftdi_tx_arb #(.N_REQ(N), .MAX_LEN(4)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .req_vld  (req_vld),
        .req_d    (req_d),
        .req_last (req_last),
        .req_rdy  (req_rdy),
        .txe      (txe),
        .wr       (wr),
        .d        (d),
        .grant    (grant),
        .busy     (busy),
        .len_err  (len_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [8:0] src_mem [N][16];
    int         src_hd [N];
    int         src_tl [N];
    logic       txe_cfg;

    logic       tr_wr [64];
    logic [7:0] tr_d  [64];
    logic [3:0] tr_g  [64];
    int         ns;
    logic [7:0] rx   [32];
    int         rx_t [32];
    int         rx_n;
    logic [7:0] ex   [32];
    int         ex_n;
    int         acc_t;
    int         len_n;
    int         len_t;
    logic       s_busy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int r, input logic [7:0] b, input logic l);
        src_mem[r][src_tl[r]] = {l, b};
        src_tl[r]++;
    endtask

    task automatic exp_b(input logic [7:0] b);
        ex[ex_n] = b;
        ex_n++;
    endtask

    task automatic exp_hdr(input logic [3:0] id);
        if (H == 1) exp_b({4'hA, id});
    endtask

    task automatic begin_scn();
        ns    = 0;
        rx_n  = 0;
        ex_n  = 0;
        acc_t = -1;
        len_n = 0;
        len_t = -1;
        for (int i = 0; i < N; i++) begin
            src_hd[i] = 0;
            src_tl[i] = 0;
        end
    endtask

    function automatic bit all_empty();
        bit e;
        e = 1'b1;
        for (int i = 0; i < N; i++) if (src_hd[i] < src_tl[i]) e = 1'b0;
        return e;
    endfunction

    // Drive at the falling edge, sample 1ns later; the transfer happens at the next rising edge.
    task automatic step();
        @(negedge clk);
        txe = txe_cfg;
        for (int i = 0; i < N; i++) begin
            if (src_hd[i] < src_tl[i]) begin
                req_vld[i]      = 1'b1;
                req_d[8*i +: 8] = src_mem[i][src_hd[i]][7:0];
                req_last[i]     = src_mem[i][src_hd[i]][8];
            end else begin
                req_vld[i]      = 1'b0;
                req_d[8*i +: 8] = 8'h00;
                req_last[i]     = 1'b0;
            end
        end
        #1;
        if (ns < 64) begin
            tr_wr[ns] = wr;
            tr_d[ns]  = d;
            tr_g[ns]  = grant;
        end
        if (!wr && rx_n < 32) begin
            rx[rx_n]   = d;
            rx_t[rx_n] = ns;
            rx_n++;
        end
        for (int i = 0; i < N; i++) begin
            if (req_vld[i] && req_rdy[i]) begin
                src_hd[i]++;
                acc_t = ns;
            end
        end
        if (len_err) begin
            len_n++;
            len_t = ns;
        end
        s_busy = busy;
        ns++;
    endtask

    task automatic run_idle(input string tag, input int maxc);
        bit done;
        done = 1'b0;
        for (int k = 0; k < maxc && !done; k++) begin
            step();
            if (all_empty() && !s_busy) done = 1'b1;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic check_rx(input string tag);
        chk({tag, "_cnt"}, rx_n, ex_n);
        for (int k = 0; k < ex_n; k++) chk($sformatf("%s_b%0d", tag, k), rx[k], ex[k]);
    endtask

    function automatic int last_rx();
        return (rx_n > 0) ? rx_n - 1 : 0;
    endfunction

    initial begin
        n_rst    = 1'b1;
        txe      = 1'b0;
        txe_cfg  = 1'b0;
        req_vld  = '0;
        req_d    = '0;
        req_last = '0;
        begin_scn();
        #2 n_rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_wr", wr, 1);
        chk("rst_d", d, 8'h00);
        chk("rst_grant", grant, 0);
        chk("rst_rdy", req_rdy, 0);
        chk("rst_busy", busy, 0);
        chk("rst_len_err", len_err, 0);
        @(negedge clk);
        n_rst = 1'b1;

        // Single 3-byte packet from requester 2.
        begin_scn();
        push(2, 8'h11, 1'b0); push(2, 8'h22, 1'b0); push(2, 8'h33, 1'b1);
        exp_hdr(4'd2); exp_b(8'h11); exp_b(8'h22); exp_b(8'h33);
        for (int s = 0; s < 8; s++) step();
        check_rx("t2");
        for (int s = 0; s < 8; s++)
            chk($sformatf("t2_wr%0d", s), tr_wr[s], (s >= 2 && s <= 4 + H) ? 0 : 1);
        chk("t2_g_on", tr_g[1], 4'b0100);
        chk("t2_g_last", tr_g[3 + H], 4'b0100);
        chk("t2_g_off", tr_g[4 + H], 4'b0000);
        chk("t2_d_hold", tr_d[7], 8'h33);
        chk("t2_len_err", len_n, 0);

        // Requesters 0 and 1 compete with two 2-byte packets each.
        begin_scn();
        push(0, 8'h01, 1'b0); push(0, 8'h02, 1'b1); push(0, 8'h03, 1'b0); push(0, 8'h04, 1'b1);
        push(1, 8'h05, 1'b0); push(1, 8'h06, 1'b1); push(1, 8'h07, 1'b0); push(1, 8'h08, 1'b1);
        exp_hdr(4'd0); exp_b(8'h01); exp_b(8'h02);
        exp_hdr(4'd1); exp_b(8'h05); exp_b(8'h06);
        exp_hdr(4'd0); exp_b(8'h03); exp_b(8'h04);
        exp_hdr(4'd1); exp_b(8'h07); exp_b(8'h08);
        run_idle("t3", 60);
        check_rx("t3");
        chk("t3_span", rx_t[last_rx()] - rx_t[0] + 1, 11 + 4 * H);

        // txe stalls five cycles with a byte held in the output register.
        begin_scn();
        push(2, 8'h41, 1'b0); push(2, 8'h42, 1'b0); push(2, 8'h43, 1'b0); push(2, 8'h44, 1'b1);
        exp_hdr(4'd2); exp_b(8'h41); exp_b(8'h42); exp_b(8'h43); exp_b(8'h44);
        for (int s = 0; s < 4; s++) step();
        txe_cfg = 1'b1;
        for (int s = 0; s < 5; s++) begin
            step();
            chk($sformatf("t4_wr%0d", s), wr, 1);
            chk($sformatf("t4_rdy%0d", s), req_rdy, 0);
            chk($sformatf("t4_d%0d", s), d, (H == 1) ? 8'h42 : 8'h43);
        end
        txe_cfg = 1'b0;
        run_idle("t4", 40);
        check_rx("t4");

        // 6 bytes against MAX_LEN=4: forced split after the fourth byte.
        begin_scn();
        push(3, 8'h61, 1'b0); push(3, 8'h62, 1'b0); push(3, 8'h63, 1'b0);
        push(3, 8'h64, 1'b0); push(3, 8'h65, 1'b0); push(3, 8'h66, 1'b1);
        exp_hdr(4'd3); exp_b(8'h61); exp_b(8'h62); exp_b(8'h63); exp_b(8'h64);
        exp_hdr(4'd3); exp_b(8'h65); exp_b(8'h66);
        run_idle("t5", 60);
        check_rx("t5");
        chk("t5_len_err_n", len_n, 1);
        chk("t5_len_err_d", tr_d[(len_t >= 0) ? len_t : 0], 8'h64);

        // Requester 0 finishes, then reset hits requester 1 mid-packet.
        begin_scn();
        push(0, 8'h70, 1'b1);
        exp_hdr(4'd0); exp_b(8'h70);
        run_idle("t6a", 20);
        check_rx("t6a");
        begin_scn();
        push(1, 8'h71, 1'b0); push(1, 8'h72, 1'b0); push(1, 8'h73, 1'b1);
        for (int s = 0; s < 3; s++) step();
        chk("t6_pre_wr", tr_wr[2], 0);
        chk("t6_pre_g", tr_g[2], 4'b0010);
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        chk("t6_rst_wr", wr, 1);
        chk("t6_rst_grant", grant, 0);
        chk("t6_rst_rdy", req_rdy, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_d", d, 8'h00);
        begin_scn();
        req_vld = '0;
        @(negedge clk);
        n_rst = 1'b1;
        begin_scn();
        push(0, 8'h80, 1'b1); push(1, 8'h81, 1'b1);
        exp_hdr(4'd0); exp_b(8'h80); exp_hdr(4'd1); exp_b(8'h81);
        run_idle("t6b", 30);
        check_rx("t6b");
        chk("t6_first_g", tr_g[1], 4'b0001);

        // One-byte packet: data byte leaves one cycle after acceptance.
        begin_scn();
        push(1, 8'h55, 1'b1);
        exp_hdr(4'd1); exp_b(8'h55);
        run_idle("t7", 20);
        check_rx("t7");
        chk("t7_lat", rx_t[last_rx()] - acc_t, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
